// File: rtl/uart_tx_framer_if.sv
// Word handshake between the TX FIFO/CSR side (master) and the UART TX framer (slave).
interface uart_tx_framer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-entry holding buffer feeding a start/data/parity/stop serializer
// that advances one bit per baud tick.
module uart_tx_framer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_BITS  = $clog2(WIDTH) + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            tick,
  uart_tx_framer_if.slave in_if,
  input  logic            parity_en,
  input  logic            parity_odd,
  input  logic            stop2,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    buf_data;
  logic                buf_full;
  logic                ready_q;
  logic [WIDTH-1:0]    shreg;
  logic [CNT_BITS-1:0] cnt;
  logic                cfg_par_en;
  logic                cfg_stop2;
  logic                par_bit;
  logic                frame_end_c;
  logic                load_c;

  assign in_if.in_ready = ready_q;

  // A frame ends on the tick leaving the last stop bit; a full buffer then reloads with no idle gap.
  assign frame_end_c = (state == ST_STOP2) || ((state == ST_STOP1) && !cfg_stop2);
  assign load_c      = tick && buf_full && ((state == ST_IDLE) || frame_end_c);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      ready_q    <= 1'b1;
      shreg      <= '0;
      cnt        <= '0;
      cfg_par_en <= 1'b0;
      cfg_stop2  <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Handshake cannot collide with a load: ready_q is low whenever the buffer is full.
      if (in_if.in_valid && ready_q) begin
        buf_data <= in_if.in_data;
        buf_full <= 1'b1;
        ready_q  <= 1'b0;
      end

      if (load_c) begin
        shreg      <= buf_data;
        buf_full   <= 1'b0;
        ready_q    <= 1'b1;
        cfg_par_en <= parity_en;
        cfg_stop2  <= stop2;
        par_bit    <= (^buf_data) ^ parity_odd;
      end

      if (tick) begin
        unique case (state)
          ST_IDLE: begin
            if (buf_full) begin
              state <= ST_START;
              tx    <= 1'b0;
              busy  <= 1'b1;
            end
          end
          ST_START: begin
            state <= ST_DATA;
            cnt   <= CNT_BITS'(WIDTH - 1);
            tx    <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
          end
          ST_DATA: begin
            if (cnt == '0) begin
              if (cfg_par_en) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP1;
                tx    <= 1'b1;
              end
            end else begin
              cnt   <= cnt - CNT_BITS'(1);
              shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              tx    <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
            end
          end
          ST_PARITY: begin
            state <= ST_STOP1;
            tx    <= 1'b1;
          end
          ST_STOP1, ST_STOP2: begin
            if ((state == ST_STOP1) && cfg_stop2) begin
              state <= ST_STOP2;
              tx    <= 1'b1;
            end else begin
              frame_done <= 1'b1;
              if (buf_full) begin
                state <= ST_START;
                tx    <= 1'b0;
              end else begin
                state <= ST_IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: an 8-bit LSB-first instance on a 16-cycle baud tick
// and a 9-bit MSB-first instance with tick held high.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tick8, tick9;
  logic pe8, po8, s2_8, pe9, po9, s2_9;
  logic tx8, busy8, fd8, tx9, busy9, fd9;
  logic tick8_q = 1'b0, tick9_q = 1'b0;

  uart_tx_framer_if #(.WIDTH(8)) if8 ();
  uart_tx_framer_if #(.WIDTH(9)) if9 ();

  uart_tx_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .CLK(clk), .RST(rst), .tick(tick8), .in_if(if8),
    .parity_en(pe8), .parity_odd(po8), .stop2(s2_8),
    .tx(tx8), .busy(busy8), .frame_done(fd8)
  );

  uart_tx_framer #(.WIDTH(9), .MSB_FIRST(1'b1)) dut9 (
    .CLK(clk), .RST(rst), .tick(tick9), .in_if(if9),
    .parity_en(pe9), .parity_odd(po9), .stop2(s2_9),
    .tx(tx9), .busy(busy9), .frame_done(fd9)
  );

  int   total = 0;
  int   bad   = 0;
  logic q8[$];
  logic q9[$];
  int   fd_cnt8 = 0, fd_cnt9 = 0;
  logic fd8_prev = 1'b0, fd9_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    tick8_q <= tick8;
    tick9_q <= tick9;
  end

  // Baud tick for the 8-bit instance: one cycle high every 16 clocks.
  initial begin
    tick8 = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      tick8 = 1'b1;
      @(negedge clk);
      tick8 = 1'b0;
    end
  end

  // Monitors: every tick edge that leaves the DUT busy presents one frame bit.
  always @(negedge clk) begin
    if (tick8_q && busy8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL dut8 unexpected bit: got tx=%0b with empty queue at %0t", tx8, $time);
      end else chk("dut8 tx bit", 32'(tx8), 32'(q8.pop_front()));
    end
    if (fd8) begin
      fd_cnt8++;
      chk("dut8 frame_done width", 32'(fd8_prev), 32'd0);
    end
    fd8_prev = fd8;
  end

  always @(negedge clk) begin
    if (tick9_q && busy9) begin
      if (q9.size() == 0) begin
        total++; bad++;
        $display("FAIL dut9 unexpected bit: got tx=%0b with empty queue at %0t", tx9, $time);
      end else chk("dut9 tx bit", 32'(tx9), 32'(q9.pop_front()));
    end
    if (fd9) begin
      fd_cnt9++;
      chk("dut9 frame_done width", 32'(fd9_prev), 32'd0);
    end
    fd9_prev = fd9;
  end

  task automatic push8(input string s);
    for (int i = 0; i < s.len(); i++) q8.push_back(s[i] == "1");
  endtask

  task automatic push9(input string s);
    for (int i = 0; i < s.len(); i++) q9.push_back(s[i] == "1");
  endtask

  task automatic send8(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if8.in_data  = d;
    if8.in_valid = 1'b1;
    while (!if8.in_ready && n < 2000) begin @(negedge clk); n++; end
    chk("dut8 handshake in time", 32'(n < 2000), 32'd1);
    @(negedge clk);
    if8.in_valid = 1'b0;
  endtask

  task automatic send9(input logic [8:0] d);
    int n = 0;
    @(negedge clk);
    if9.in_data  = d;
    if9.in_valid = 1'b1;
    while (!if9.in_ready && n < 2000) begin @(negedge clk); n++; end
    chk("dut9 handshake in time", 32'(n < 2000), 32'd1);
    @(negedge clk);
    if9.in_valid = 1'b0;
  endtask

  task automatic wait_busy8();
    int n = 0;
    while (!busy8 && n < 200) begin @(negedge clk); n++; end
    chk("dut8 load in time", 32'(busy8), 32'd1);
  endtask

  task automatic wait_fd8(input int target);
    int n = 0;
    while (fd_cnt8 < target && n < 5000) begin @(negedge clk); n++; end
    chk("dut8 frame_done count reached", 32'(fd_cnt8 >= target), 32'd1);
  endtask

  task automatic wait_fd9(input int target);
    int n = 0;
    while (fd_cnt9 < target && n < 500) begin @(negedge clk); n++; end
    chk("dut9 frame_done count reached", 32'(fd_cnt9 >= target), 32'd1);
  endtask

  task automatic wait_tick8();
    int n = 0;
    @(negedge clk);
    while (!tick8_q && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    rst = 1'b1;
    tick9 = 1'b0;
    {pe8, po8, s2_8, pe9, po9, s2_9} = '0;
    if8.in_data = '0; if8.in_valid = 1'b0;
    if9.in_data = '0; if9.in_valid = 1'b0;

    // Reset state, then idle with ticks and no input.
    repeat (2) @(negedge clk);
    chk("rst tx", 32'(tx8), 32'd1);
    chk("rst in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst busy", 32'(busy8), 32'd0);
    chk("rst frame_done", 32'(fd8), 32'd0);
    chk("rst dut9 tx", 32'(tx9), 32'd1);
    chk("rst dut9 in_ready", 32'(if9.in_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      chk("idle tx", 32'(tx8), 32'd1);
      chk("idle busy", 32'(busy8), 32'd0);
      chk("idle in_ready", 32'(if8.in_ready), 32'd1);
    end

    // 0xA5, no parity, one stop.
    push8("0101001011");
    send8(8'hA5);
    wait_fd8(1);
    chk("basic idle after frame", 32'(busy8), 32'd0);

    // 0xA5, even parity, two stop bits.
    {pe8, po8, s2_8} = 3'b101;
    push8("010100101011");
    send8(8'hA5);
    wait_fd8(2);

    // 0xA5, odd parity.
    {pe8, po8, s2_8} = 3'b110;
    push8("01010010111");
    send8(8'hA5);
    wait_fd8(3);

    // 0x07, even parity.
    {pe8, po8, s2_8} = 3'b100;
    push8("01110000011");
    send8(8'h07);
    wait_fd8(4);

    // Back-to-back 0x55 then 0x0F.
    {pe8, po8, s2_8} = 3'b000;
    push8("0101010101");
    push8("0111100001");
    send8(8'h55);
    wait_busy8();
    chk("b2b in_ready after load", 32'(if8.in_ready), 32'd1);
    send8(8'h0F);
    wait_fd8(5);
    chk("b2b busy at first frame end", 32'(busy8), 32'd1);
    chk("b2b start bit follows stop", 32'(tx8), 32'd0);
    wait_fd8(6);

    // Config toggled mid-frame has no effect on the frame in flight.
    push8("0101001011");
    send8(8'hA5);
    wait_busy8();
    repeat (40) @(negedge clk);
    {pe8, po8, s2_8} = 3'b111;
    wait_fd8(7);
    {pe8, po8, s2_8} = 3'b000;

    // Reset during DATA: start plus three data bits, then abort.
    push8("0101");
    send8(8'hA5);
    wait_busy8();
    repeat (3) wait_tick8();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", 32'(tx8), 32'd1);
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst in_ready", 32'(if8.in_ready), 32'd1);
    chk("midrst frame_done", 32'(fd8), 32'd0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst no frame_done", 32'(fd_cnt8), 32'd7);
    chk("midrst stays idle", 32'(busy8), 32'd0);
    chk("midrst queue drained", 32'(q8.size()), 32'd0);

    // 9-bit MSB-first instance with tick held high.
    @(negedge clk);
    tick9 = 1'b1;
    push9("01101000111");
    send9(9'h1A3);
    wait_fd9(1);
    {pe9, po9, s2_9} = 3'b111;
    push9("0110100011011");
    send9(9'h1A3);
    wait_fd9(2);
    repeat (4) @(negedge clk);

    chk("dut8 queue empty", 32'(q8.size()), 32'd0);
    chk("dut9 queue empty", 32'(q9.size()), 32'd0);
    chk("dut8 frame count", 32'(fd_cnt8), 32'd7);
    chk("dut9 frame count", 32'(fd_cnt9), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer: successor of the fixed 8-bit serializer.
- Accepts parallel words over a valid/ready handshake into a one-entry holding buffer.
- Emits complete frames on `tx`, one bit per baud tick: start bit, WIDTH data bits, optional even/odd parity bit, and 1 or 2 stop bits.
- Sits between the UART TX FIFO/CSR logic and the pad; the baud generator supplies `tick`.

Parameters:
- WIDTH, 8, data bits per frame (5..9).
- MSB_FIRST, 0, 0 = LSB transmitted first; 1 = MSB first.
- CNT_BITS, $clog2(WIDTH)+1, data-bit counter width (derived; do not override).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- tick  input  1  baud enable, one CLK-cycle pulse per bit period.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding buffer empty; registered.
- parity_en  input  1  1 = append parity bit.
- parity_odd  input  1  1 = odd parity; 0 = even parity.
- stop2  input  1  1 = two stop bits; 0 = one stop bit.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high whenever the state is not IDLE.
- frame_done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (RST=1 at a CLK edge, sampled synchronously):
  - Outputs: tx=1, in_ready=1, busy=0, frame_done=0.
  - State: IDLE, buffer empty, counters cleared.
  - Reset mid-frame aborts the frame; tx returns high on that edge. No partial-frame completion and no frame_done.
- Handshake:
  - Transfer occurs on an edge where in_valid && in_ready. in_data is captured into the buffer; in_ready drops on the next cycle.
  - in_ready depends only on buffer state, with no combinational path from in_valid.
  - The buffer empties on the edge the FSM loads it.
  - A transfer never coincides with a load: in_ready is 0 whenever the buffer is full.
- Load:
  - Occurs on a tick edge in IDLE with the buffer full, or on the tick ending the final stop bit with the buffer full.
  - Copies the buffer into the shift register.
  - Latches parity_en, parity_odd and stop2 into per-frame config. Changes to these inputs mid-frame have no effect until the next load.
- FSM states, all transitions only on edges where tick=1 (otherwise state holds):
  - IDLE: tx=1; go to START on load.
  - START: tx=0; go to DATA with bit counter = WIDTH-1.
  - DATA: tx = current data bit (bit 0 first when MSB_FIRST=0, bit WIDTH-1 first when MSB_FIRST=1). Shift and decrement each tick. When the counter is 0 on a tick, go to PARITY if parity_en, else STOP1.
  - PARITY: tx = ^data for even parity, ~^data for odd; parity is computed over the loaded word. Go to STOP1.
  - STOP1: tx=1. Go to STOP2 if stop2. Otherwise the frame ends: go to START if buffer full (load), else IDLE.
  - STOP2: tx=1; frame ends with the same exit rule as STOP1.
- Timing:
  - tx changes only on tick edges, so each bit lasts exactly one tick interval.
  - The first start bit appears on the tick edge that loads from IDLE; first-tick latency equals the wait for the next tick after buffer fill.
  - frame_done is asserted for the single CLK cycle following the frame-ending tick edge.
  - Back-to-back frames have zero idle bits between them.
- Frame length: 1 + WIDTH + parity_en + 1 + stop2 ticks.
- tick asserted while in IDLE with an empty buffer: no effect.
- tick held high continuously: advances one bit per CLK. This is legal.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, ticks every 16 CLK → tx=1, in_ready=1, busy=0, frame_done=0 throughout with no input.
- Basic frame: WIDTH=8, LSB first, in_data=0xA5, no parity, 1 stop → tx per tick = 0,1,0,1,0,0,1,0,1,1. busy high for 10 ticks; frame_done pulses once, 1 cycle.
- Parity and stop bits:
  - 0xA5, even parity, stop2 → 12-bit frame, parity bit 0, two 1s.
  - 0xA5, odd parity → parity bit 1.
  - 0x07, even parity → parity bit 1.
- Back-to-back: 0x55 then 0x0F presented while the first is sending → second start bit immediately follows stop bit, with no idle tick. in_ready reasserts one cycle after the first load.
- Mid-frame config change and reset:
  - Toggle parity_en/stop2 during DATA → current frame unaffected.
  - Assert RST during DATA → tx=1 on that edge, buffer empty, no frame_done.
- Parametrised build: MSB_FIRST=1, WIDTH=9, in_data=0x1A3, tick high every cycle → data bits 1,1,0,1,0,0,0,1,1 on consecutive CLKs.
